// File: rtl/rv32_hart_pc_seq.sv
// rv32_hart_pc_seq
// Barrel-style PC sequencer for a fine-grained multithreaded RV32 core.
// A slot pointer visits the harts round-robin, one per unstalled cycle. The
// hart that owns the slot fetches either its own PC or, when it has a pending
// interrupt, the shared trap vector. Execute can redirect any hart's PC at any
// time. When two updates hit the same hart on the same edge, a taken interrupt
// wins over a redirect, and a redirect wins over the sequential +4.
//
// Optional feature: define RV32_NPC_ALIGN_CHK_EN to reject redirects whose
// target is not 4-byte aligned. A rejected redirect is reported for one cycle
// on misalign_err / misalign_hart. When the macro is not defined, redirects
// are applied unchecked and both report outputs are tied to zero.

module rv32_hart_pc_seq #(
  parameter int                NUM_HARTS = 8,
  parameter int                PC_W      = 32,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  localparam int               HW        = $clog2(NUM_HARTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic [NUM_HARTS-1:0] hart_en,
  output logic                 fetch_valid,
  output logic [HW-1:0]        fetch_hart,
  output logic [PC_W-1:0]      fetch_pc,
  input  logic                 redir_valid,
  input  logic [HW-1:0]        redir_hart,
  input  logic [PC_W-1:0]      redir_pc,
  input  logic [NUM_HARTS-1:0] irq_valid,
  input  logic [PC_W-1:0]      irq_vec,
  output logic [NUM_HARTS-1:0] irq_ack,
  output logic                 misalign_err,
  output logic [HW-1:0]        misalign_hart
);

  localparam logic [HW-1:0]   LAST_HART = HW'(NUM_HARTS - 1);
  localparam logic [HW:0]     HART_CNT  = (HW + 1)'(NUM_HARTS);
  localparam logic [PC_W-1:0] PC_STEP   = PC_W'(4);

  logic [PC_W-1:0]      pc      [NUM_HARTS];
  logic [PC_W-1:0]      pc_next [NUM_HARTS];
  logic [HW-1:0]        cur;
  logic [NUM_HARTS-1:0] pend;
  logic [NUM_HARTS-1:0] pend_next;
  logic                 redir_in_range;
  logic                 redir_misaligned;
  logic                 redir_apply;

  // The current slot owner fetches unless the pipe is stalled or it is parked.
  assign fetch_hart  = cur;
  assign fetch_valid = !stall && hart_en[cur];
  assign fetch_pc    = pend[cur] ? irq_vec : pc[cur];

  // With a non-power-of-two hart count the index field can name harts that
  // do not exist; such redirects are ignored.
  assign redir_in_range = {1'b0, redir_hart} < HART_CNT;

`ifdef RV32_NPC_ALIGN_CHK_EN
  assign redir_misaligned = redir_pc[1:0] != 2'b00;

  // Report a rejected redirect for exactly the cycle after it was presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err  <= 1'b0;
      misalign_hart <= '0;
    end else begin
      misalign_err  <= redir_valid && redir_in_range && redir_misaligned;
      misalign_hart <= (redir_valid && redir_in_range && redir_misaligned) ? redir_hart : '0;
    end
  end
`else
  assign redir_misaligned = 1'b0;
  assign misalign_err     = 1'b0;
  assign misalign_hart    = '0;
`endif

  assign redir_apply = redir_valid && redir_in_range && !redir_misaligned;

  // An interrupt is taken when its hart actually fetches in its own slot.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    irq_ack = '0;
    if (fetch_valid && pend[cur]) irq_ack[cur] = 1'b1;
  end

  // Next PC per hart: taken interrupt > redirect > sequential advance > hold.
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      pc_next[h] = pc[h];
      if (irq_ack[h])
        pc_next[h] = fetch_pc + PC_STEP;
      else if (redir_apply && redir_hart == HW'(h))
        pc_next[h] = redir_pc;
      else if (fetch_valid && cur == HW'(h))
        pc_next[h] = pc[h] + PC_STEP;
    end
    // A new request on the same edge as an acknowledge keeps the flag set.
    pend_next = irq_valid | (pend & ~irq_ack);
  end

  // Architectural state: per-hart PCs, pending flags and the slot pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the PC array is a small register file that must come up at
      // RESET_PC, so unlike a RAM it is reset element by element.
      for (int h = 0; h < NUM_HARTS; h++) pc[h] <= RESET_PC;
      pend <= '0;
      cur  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      for (int h = 0; h < NUM_HARTS; h++) pc[h] <= pc_next[h];
      pend <= pend_next;
      if (!stall) cur <= (cur == LAST_HART) ? '0 : cur + 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32_hart_pc_seq.sv
// tb_rv32_hart_pc_seq
// Self-checking bench for rv32_hart_pc_seq with five harts, so the slot
// pointer wraps at a non-power-of-two count and hart indices 5..7 are invalid.
// A behavioural model holds every hart's PC and pending flag as plain
// variables and predicts the fetch outputs each cycle. Inputs change on the
// falling edge and outputs are compared 1 ns later. Directed scenarios come
// first, followed by a randomized run that includes a reset in the middle.

module tb_rv32_hart_pc_seq;

  localparam int          N      = 5;
  localparam int          HW     = $clog2(N);
  localparam logic [31:0] RST_PC = 32'h0;
`ifdef RV32_NPC_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          stall = 1'b0;
  logic [N-1:0]  hart_en = '1;
  logic          fetch_valid;
  logic [HW-1:0] fetch_hart;
  logic [31:0]   fetch_pc;
  logic          redir_valid = 1'b0;
  logic [HW-1:0] redir_hart = '0;
  logic [31:0]   redir_pc = '0;
  logic [N-1:0]  irq_valid = '0;
  logic [31:0]   irq_vec = 32'h80;
  logic [N-1:0]  irq_ack;
  logic          misalign_err;
  logic [HW-1:0] misalign_hart;

  int checks   = 0;
  int failures = 0;

  // Reference state: one PC and one pending flag per hart, plus the slot owner.
  logic [31:0]   m_pc [N];
  logic [N-1:0]  m_pend;
  int            m_cur;
  logic          m_err;
  logic [HW-1:0] m_errh;
  logic [31:0]   vec_r = 32'h80;

  rv32_hart_pc_seq #(
    .NUM_HARTS (N),
    .PC_W      (32),
    .RESET_PC  (RST_PC)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .hart_en       (hart_en),
    .fetch_valid   (fetch_valid),
    .fetch_hart    (fetch_hart),
    .fetch_pc      (fetch_pc),
    .redir_valid   (redir_valid),
    .redir_hart    (redir_hart),
    .redir_pc      (redir_pc),
    .irq_valid     (irq_valid),
    .irq_vec       (irq_vec),
    .irq_ack       (irq_ack),
    .misalign_err  (misalign_err),
    .misalign_hart (misalign_hart)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pc[i] = RST_PC;
    m_pend = '0;
    m_cur  = 0;
    m_err  = 1'b0;
    m_errh = '0;
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then
  // advance the model to the state it will hold after the next rising edge.
  task automatic step(input logic s, input logic [N-1:0] en, input logic rv,
                      input logic [HW-1:0] rh, input logic [31:0] rpc,
                      input logic [N-1:0] irq);
    logic        e_fv;
    logic [31:0] e_fpc;
    logic [N-1:0] e_ack;
    logic        taken;
    logic        acc;
    logic        bad;
    @(negedge clk);
    rst_n       = 1'b1;
    stall       = s;
    hart_en     = en;
    redir_valid = rv;
    redir_hart  = rh;
    redir_pc    = rpc;
    irq_valid   = irq;
    irq_vec     = vec_r;
    #1;
    e_fv  = !s && en[m_cur];
    taken = e_fv && m_pend[m_cur];
    e_fpc = m_pend[m_cur] ? vec_r : m_pc[m_cur];
    e_ack = '0;
    if (taken) e_ack[m_cur] = 1'b1;
    check("fetch_valid",   64'(fetch_valid),   64'(e_fv));
    check("fetch_hart",    64'(fetch_hart),    64'(m_cur));
    check("fetch_pc",      64'(fetch_pc),      64'(e_fpc));
    check("irq_ack",       64'(irq_ack),       64'(e_ack));
    check("misalign_err",  64'(misalign_err),  64'(m_err));
    check("misalign_hart", 64'(misalign_hart), 64'(m_errh));

    bad = rv && (int'(rh) < N) && (rpc[1:0] != 2'b00);
    acc = rv && (int'(rh) < N) && !(ALIGN_CHK && bad);
    if (acc && !(taken && int'(rh) == m_cur)) m_pc[int'(rh)] = rpc;
    if (taken)
      m_pc[m_cur] = e_fpc + 32'd4;
    else if (e_fv && !(acc && int'(rh) == m_cur))
      m_pc[m_cur] = m_pc[m_cur] + 32'd4;
    for (int h = 0; h < N; h++) begin
      if (irq[h])        m_pend[h] = 1'b1;
      else if (e_ack[h]) m_pend[h] = 1'b0;
    end
    if (!s) m_cur = (m_cur + 1) % N;
    m_err  = ALIGN_CHK && bad;
    m_errh = m_err ? rh : '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 5'b11111, 1'b0, 3'd0, 32'h0, 5'b00000);
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    stall       = 1'b0;
    redir_valid = 1'b0;
    irq_valid   = '0;
    #1;
    check("rst_fetch_hart",    64'(fetch_hart),    64'(0));
    check("rst_fetch_pc",      64'(fetch_pc),      64'(RST_PC));
    check("rst_irq_ack",       64'(irq_ack),       64'(0));
    check("rst_misalign_err",  64'(misalign_err),  64'(0));
    check("rst_misalign_hart", 64'(misalign_hart), 64'(0));
    model_reset();
  endtask

  initial begin
    logic          r_s;
    logic [N-1:0]  r_en;
    logic          r_rv;
    logic [HW-1:0] r_rh;
    logic [31:0]   r_pc;
    logic [N-1:0]  r_irq;
    logic [31:0]   tmp;

    // Power-on reset, held across two rising edges.
    #2;
    do_reset();
    repeat (2) @(posedge clk);

    // Plain round-robin: harts 0..4 fetch 0, then 4, then 8.
    idle(11);

    // Stall for three cycles: slot owner and all PCs hold.
    repeat (3) step(1'b1, 5'b11111, 1'b0, 3'd0, 32'h0, 5'b00000);
    idle(5);

    // Redirect hart 2 to 0x100; its next slots fetch 0x100 then 0x104.
    step(1'b0, 5'b11111, 1'b1, 3'd2, 32'h100, 5'b00000);
    idle(11);

    // Interrupt on hart 1, and a colliding redirect in hart 1's slot.
    vec_r = 32'h80;
    step(1'b0, 5'b11111, 1'b0, 3'd0, 32'h0, 5'b00010);
    for (int k = 0; k < N + 1; k++)
      step(1'b0, 5'b11111, m_cur == 1, 3'd1, 32'h200, 5'b00000);
    idle(11);

    // Misaligned redirect to hart 3.
    step(1'b0, 5'b11111, 1'b1, 3'd3, 32'h102, 5'b00000);
    idle(11);

    // Redirects naming a hart that does not exist are ignored.
    step(1'b0, 5'b11111, 1'b1, 3'd6, 32'h300, 5'b00000);
    step(1'b0, 5'b11111, 1'b1, 3'd7, 32'h304, 5'b00000);
    idle(6);

    // Hart 0 parked for eight cycles; an interrupt raised for it stays pending.
    step(1'b0, 5'b11110, 1'b0, 3'd0, 32'h0, 5'b00001);
    repeat (7) step(1'b0, 5'b11110, 1'b0, 3'd0, 32'h0, 5'b00000);
    idle(6);

    // Redirect while a hart is parked and the pipe is stalled still lands.
    step(1'b1, 5'b01111, 1'b1, 3'd4, 32'hFFFF_FFFC, 5'b00000);
    idle(12);

    // Reset mid-run with interrupts pending and a redirect in flight.
    step(1'b0, 5'b11111, 1'b0, 3'd0, 32'h0, 5'b11111);
    step(1'b0, 5'b11111, 1'b1, 3'd0, 32'h400, 5'b00000);
    do_reset();
    idle(7);

    // Randomized traffic with a reset roughly halfway through.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      if ($urandom_range(0, 63) == 0) begin
        tmp   = $urandom;
        vec_r = {tmp[31:2], 2'b00};
      end
      r_s = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < N; b++) begin
        r_en[b]  = ($urandom_range(0, 7) != 0);
        r_irq[b] = ($urandom_range(0, 15) == 0);
      end
      r_rv = ($urandom_range(0, 3) == 0);
      r_rh = HW'($urandom_range(0, 7));
      r_pc = $urandom;
      if ($urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
      if ($urandom_range(0, 31) == 0) r_pc = 32'hFFFF_FFFC;
      step(r_s, r_en, r_rv, r_rh, r_pc, r_irq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32_hart_pc_seq.md
RV32_HART_PC_SEQ -- requirements
Module: rv32_hart_pc_seq

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 8, number of hardware threads (2..16, need not be a power of two).
REQ-002 SHALL have parameter PC_W, default 32, PC width in bits.
REQ-003 SHALL have parameter RESET_PC, default 0, PC loaded into every hart at reset.
REQ-004 SHALL have localparam HW = $clog2(NUM_HARTS), hart-index width.
REQ-005 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port stall  in  1  freeze slot pointer and sequential PC advance.
REQ-008 SHALL have port hart_en  in  NUM_HARTS  per-hart run enable.
REQ-009 SHALL have port fetch_valid  out  1  fetch slot issued this cycle.
REQ-010 SHALL have port fetch_hart  out  HW  hart owning current slot.
REQ-011 SHALL have port fetch_pc  out  PC_W  PC to fetch this cycle.
REQ-012 SHALL have port redir_valid  in  1  taken branch/jump/mret redirect from execute.
REQ-013 SHALL have port redir_hart  in  HW  hart being redirected.
REQ-014 SHALL have port redir_pc  in  PC_W  redirect target.
REQ-015 SHALL have port irq_valid  in  NUM_HARTS  per-hart interrupt request pulse.
REQ-016 SHALL have port irq_vec  in  PC_W  shared trap vector.
REQ-017 SHALL have port irq_ack  out  NUM_HARTS  one-cycle pulse when a hart's interrupt is taken.
REQ-018 SHALL have ports misalign_err  out  1 and misalign_hart  out  HW  rejected-redirect report.

Function
REQ-019 SHALL hold per-hart PC registers pc[0..NUM_HARTS-1], a slot pointer cur, and per-hart pending-interrupt flags pend.
REQ-020 cur SHALL advance by 1 each cycle stall=0, wrapping NUM_HARTS-1 -> 0; held when stall=1.
REQ-021 fetch_hart SHALL equal cur; fetch_valid SHALL equal !stall && hart_en[cur] (combinational from registers and inputs).
REQ-022 fetch_pc SHALL equal irq_vec when pend[cur]=1, else pc[cur].
REQ-023 On a fetch_valid cycle, pc[cur] SHALL become fetch_pc+4 at the next edge, modulo 2^PC_W.
REQ-024 pend[h] SHALL set on irq_valid[h]=1 and clear at the edge its interrupt is taken; set dominates clear for same-edge new request.
REQ-025 Interrupt taken for hart h SHALL mean a fetch_valid cycle with cur=h and pend[h]=1; irq_ack[h] SHALL be 1 in that same cycle only.
REQ-026 redir_valid=1 SHALL load pc[redir_hart] <= redir_pc at the next edge regardless of stall or hart_en.
REQ-027 Same-hart, same-edge priority SHALL be: interrupt taken > redirect > sequential +4; a redirect losing to an interrupt SHALL be dropped.
REQ-028 redir_hart >= NUM_HARTS SHALL be ignored.
REQ-029 A disabled hart (hart_en=0) SHALL keep its PC and pend; its slot still consumes a cycle.

Reset
REQ-030 While rst_n=0: pc[*]=RESET_PC, cur=0, pend=0, misalign_err=0, misalign_hart=0; outputs are then fetch_hart=0, fetch_pc=RESET_PC, irq_ack=0.
REQ-031 Reset asserted mid-operation SHALL discard pending interrupts and redirects immediately.

Configuration
REQ-032 With RV32_NPC_ALIGN_CHK_EN defined, a redirect with redir_pc[1:0]!=0 SHALL not update any PC, and misalign_err SHALL be 1 for exactly the following cycle with misalign_hart=redir_hart.
REQ-033 Without RV32_NPC_ALIGN_CHK_EN, redirects SHALL apply unchecked and misalign_err/misalign_hart SHALL be constant 0.

Verification
REQ-034 NUM_HARTS=4, all enabled, no stall, 9 cycles after reset -> fetch_hart 0,1,2,3,0,..., fetch_pc 0,0,0,0,4,4,4,4,8.
REQ-035 NUM_HARTS=5 -> fetch_hart wraps 4->0; stall=1 for 3 cycles holds fetch_hart and all PCs.
REQ-036 redir_valid, redir_hart=2, redir_pc=0x100 -> hart 2's next slot fetches 0x100, following slot 0x104; other harts unaffected.
REQ-037 irq_valid[1] pulse with irq_vec=0x80 and redir to hart 1 (0x200) on its slot -> irq_ack[1]=1, fetch_pc=0x80, next hart-1 fetch 0x84.
REQ-038 Align check enabled, redir_pc=0x102 hart 3 -> pc[3] unchanged, misalign_err=1 one cycle, misalign_hart=3; disabled build -> next fetch 0x102.
REQ-039 hart_en[0]=0 for 8 cycles -> fetch_valid=0 in hart-0 slots, pc[0] held; rst_n low mid-run -> all PCs RESET_PC, pend cleared.
